// File: rtl/ipd_queue_if.sv
// Bundle of the IF -> pre-decode queue -> ID handshake and decoded head entry.
// The queue drives the slave side; the fetch/decode environment drives the master side.
interface ipd_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_WD = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             IF_to_IPD_valid;
    logic [PC_WD-1:0] IF_pc;
    logic [31:0]      IF_inst;
    logic             IPD_allow_in;
    logic             br_taken_cancel;
    logic             ID_allow_in;
    logic             IPD_to_ID_valid;
    logic [PC_WD-1:0] out_pc;
    logic [31:0]      out_inst;
    logic [4:0]       out_raddr1;
    logic [4:0]       out_raddr2;
    logic [4:0]       out_waddr;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [CW-1:0]    occupancy;

    modport master (
        output IF_to_IPD_valid, IF_pc, IF_inst, br_taken_cancel, ID_allow_in,
        input  IPD_allow_in, IPD_to_ID_valid, out_pc, out_inst, out_raddr1,
               out_raddr2, out_waddr, out_imm, out_illegal, occupancy
    );

    modport slave (
        input  IF_to_IPD_valid, IF_pc, IF_inst, br_taken_cancel, ID_allow_in,
        output IPD_allow_in, IPD_to_ID_valid, out_pc, out_inst, out_raddr1,
               out_raddr2, out_waddr, out_imm, out_illegal, occupancy
    );
endinterface

// File: rtl/ipd_queue.sv
// Pre-decode stage: decodes each fetched instruction once on entry and holds
// the decoded results in a DEPTH-entry FIFO that ID reads from the head.
module ipd_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WD    = 32,
    parameter int LINK_REG = 1
) (
    input logic          clk,
    input logic          reset,
    ipd_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PC_WD-1:0] pc;
        logic [31:0]      inst;
        logic [4:0]       raddr1;
        logic [4:0]       raddr2;
        logic [4:0]       waddr;
        logic [31:0]      imm;
        logic             illegal;
    } entry_t;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        entry_q [DEPTH];
    entry_t        dec;
    logic          push, pop, allow_in, head_valid;

    // Instruction field slices and opcode groups
    logic [31:0] inst;
    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [5:0]  op6;
    logic [4:0]  f_rd, f_rj, f_rk;

    always_comb begin
        inst = bus.IF_inst;
        op17 = inst[31:15];
        op10 = inst[31:22];
        op7  = inst[31:25];
        op6  = inst[31:26];
        f_rd = inst[4:0];
        f_rj = inst[9:5];
        f_rk = inst[14:10];

        dec         = '0;
        dec.pc      = bus.IF_pc;
        dec.inst    = inst;
        dec.illegal = 1'b0;

        if (op17 inside {17'h00020, 17'h00022, 17'h00038, 17'h0002A, 17'h00028,
                         17'h00029, 17'h0002B, 17'h00024, 17'h00025}) begin
            // R-type: add.w sub.w mul.w or nor and xor slt sltu
            dec.raddr1 = f_rk;
            dec.raddr2 = f_rj;
            dec.waddr  = f_rd;
        end else if (op17 inside {17'h00081, 17'h00089, 17'h00091}) begin
            // slli.w srli.w srai.w
            dec.raddr1 = f_rj;
            dec.waddr  = f_rd;
            dec.imm    = {27'b0, inst[14:10]};
        end else if (op10 inside {10'h00A, 10'h0A0, 10'h0A2}) begin
            // addi.w ld.b ld.w
            dec.raddr1 = f_rj;
            dec.waddr  = f_rd;
            dec.imm    = {{20{inst[21]}}, inst[21:10]};
        end else if (op10 inside {10'h00E, 10'h00D}) begin
            // ori andi
            dec.raddr1 = f_rj;
            dec.waddr  = f_rd;
            dec.imm    = {20'b0, inst[21:10]};
        end else if (op10 inside {10'h0A4, 10'h0A6}) begin
            // st.b st.w: store data comes from the rd field
            dec.raddr1 = f_rj;
            dec.raddr2 = f_rd;
            dec.imm    = {{20{inst[21]}}, inst[21:10]};
        end else if (op7 inside {7'h0A, 7'h0E}) begin
            // lu12i.w pcaddu12i
            dec.waddr = f_rd;
            dec.imm   = {inst[24:5], 12'b0};
        end else if (op6 == 6'h13) begin
            // jirl
            dec.raddr1 = f_rj;
            dec.waddr  = f_rd;
            dec.imm    = {{14{inst[25]}}, inst[25:10], 2'b0};
        end else if (op6 inside {6'h16, 6'h17}) begin
            // beq bne
            dec.raddr1 = f_rj;
            dec.raddr2 = f_rd;
            dec.imm    = {{14{inst[25]}}, inst[25:10], 2'b0};
        end else if (op6 inside {6'h14, 6'h15}) begin
            // b bl: offs26 high part sits in inst[9:0], low part in inst[25:10]
            dec.imm = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b0};
            if (op6 == 6'h15) begin
                dec.waddr = 5'(LINK_REG);
            end
        end else begin
            dec.illegal = 1'b1;
        end
    end

    assign head_valid = (count_q != '0);
    assign allow_in   = (count_q != CW'(DEPTH)) | bus.ID_allow_in;
    assign push       = bus.IF_to_IPD_valid & allow_in & ~bus.br_taken_cancel;
    assign pop        = head_valid & bus.ID_allow_in & ~bus.br_taken_cancel;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.br_taken_cancel) begin
            // Flush: queue empties; the same-cycle push never reached storage
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head outputs are never X
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset) begin
                entry_q[gi] <= '0;
            end else if (push && (wr_ptr_q == AW'(gi))) begin
                entry_q[gi] <= dec;
            end
        end
    end

    assign bus.IPD_allow_in    = allow_in;
    assign bus.IPD_to_ID_valid = head_valid;
    assign bus.occupancy       = count_q;
    assign bus.out_pc          = entry_q[rd_ptr_q].pc;
    assign bus.out_inst        = entry_q[rd_ptr_q].inst;
    assign bus.out_raddr1      = entry_q[rd_ptr_q].raddr1;
    assign bus.out_raddr2      = entry_q[rd_ptr_q].raddr2;
    assign bus.out_waddr       = entry_q[rd_ptr_q].waddr;
    assign bus.out_imm         = entry_q[rd_ptr_q].imm;
    assign bus.out_illegal     = entry_q[rd_ptr_q].illegal;
endmodule

// File: tb/tb_ipd_queue.sv
// Directed bench for ipd_queue: decode fields, FIFO order, full/stall,
// flush, reset mid-operation and pointer wrap-around.
module tb_ipd_queue;
    localparam int DEPTH = 4;
    localparam int PC_WD = 32;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ipd_queue_if #(.DEPTH(DEPTH), .PC_WD(PC_WD)) bus ();

    ipd_queue #(.DEPTH(DEPTH), .PC_WD(PC_WD), .LINK_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        bus.IF_to_IPD_valid = 1'b1;
        bus.IF_pc           = pc;
        bus.IF_inst         = inst;
        $display("push pc=%08h inst=%08h allow_in=%0b id_allow=%0b", pc, inst,
                 bus.IPD_allow_in, bus.ID_allow_in);
        step();
        bus.IF_to_IPD_valid = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        bus.IF_to_IPD_valid = 1'b0;
        bus.IF_pc           = '0;
        bus.IF_inst         = '0;
        bus.br_taken_cancel = 1'b0;
        bus.ID_allow_in     = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_valid", bus.IPD_to_ID_valid, 0);
        check("rst_allow", bus.IPD_allow_in, 1);
        check("rst_occ", bus.occupancy, 0);

        // add.w r4,r5,r7 pushed and consumed immediately
        bus.ID_allow_in = 1'b1;
        push(32'h1C000000, 32'h00101CA4);
        check("add_valid", bus.IPD_to_ID_valid, 1);
        check("add_pc", bus.out_pc, 32'h1C000000);
        check("add_r1", bus.out_raddr1, 7);
        check("add_r2", bus.out_raddr2, 5);
        check("add_w", bus.out_waddr, 4);
        check("add_ill", bus.out_illegal, 0);
        step();
        check("add_gone", bus.IPD_to_ID_valid, 0);

        // addi.w r1,r0,-1 held by ID, then bl +16 pushed while addi pops
        bus.ID_allow_in = 1'b0;
        push(32'h1C000004, 32'h02BFFC01);
        check("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        check("addi_r1", bus.out_raddr1, 0);
        check("addi_r2", bus.out_raddr2, 0);
        check("addi_w", bus.out_waddr, 1);
        bus.ID_allow_in = 1'b1;
        push(32'h1C000008, 32'h54001000);
        bus.ID_allow_in = 1'b0;
        check("bl_occ", bus.occupancy, 1);
        check("bl_pc", bus.out_pc, 32'h1C000008);
        check("bl_imm", bus.out_imm, 32'h00000010);
        check("bl_w", bus.out_waddr, 1);
        check("bl_r1", bus.out_raddr1, 0);
        bus.ID_allow_in = 1'b1;
        step();
        bus.ID_allow_in = 1'b0;
        check("bl_drain", bus.occupancy, 0);

        // Fill to DEPTH with ID stalled; the fifth fetch is held off
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'h00101CA4);
        check("full_occ", bus.occupancy, 4);
        check("full_allow", bus.IPD_allow_in, 0);
        push(32'h110, 32'h00101CA4);
        check("held_occ", bus.occupancy, 4);
        check("held_head", bus.out_pc, 32'h100);
        bus.ID_allow_in = 1'b1;
        #1;
        check("full_allow_pop", bus.IPD_allow_in, 1);
        push(32'h110, 32'h00101CA4);
        check("pp_occ", bus.occupancy, 4);
        for (int i = 1; i <= 4; i++) begin
            check("fifo_pc", bus.out_pc, 32'h100 + 32'(4 * i));
            $display("pop pc=%08h", bus.out_pc);
            step();
        end
        check("fifo_empty", bus.occupancy, 0);
        bus.ID_allow_in = 1'b0;

        // Flush with 3 queued and a concurrent fetch
        for (int i = 0; i < 3; i++) push(32'h200 + 32'(4 * i), 32'h00101CA4);
        check("pre_flush_occ", bus.occupancy, 3);
        bus.br_taken_cancel = 1'b1;
        push(32'h20C, 32'h00101CA4);
        bus.br_taken_cancel = 1'b0;
        check("flush_occ", bus.occupancy, 0);
        check("flush_valid", bus.IPD_to_ID_valid, 0);
        push(32'h210, 32'h00101CA4);
        check("post_flush_occ", bus.occupancy, 1);
        check("post_flush_pc", bus.out_pc, 32'h210);
        bus.ID_allow_in = 1'b1;
        step();
        bus.ID_allow_in = 1'b0;

        // Illegal word, then branch immediates through the queue
        push(32'h300, 32'hFFFFFFFF);
        check("ill_flag", bus.out_illegal, 1);
        check("ill_r1", bus.out_raddr1, 0);
        check("ill_r2", bus.out_raddr2, 0);
        check("ill_w", bus.out_waddr, 0);
        check("ill_imm", bus.out_imm, 0);
        bus.ID_allow_in = 1'b1;
        push(32'h304, 32'h58000C85); // beq r4,r5,+12
        check("beq_r1", bus.out_raddr1, 4);
        check("beq_r2", bus.out_raddr2, 5);
        check("beq_w", bus.out_waddr, 0);
        check("beq_imm", bus.out_imm, 32'h0000000C);
        push(32'h308, 32'h53FFFFFF); // b -4
        check("b_neg_imm", bus.out_imm, 32'hFFFFFFFC);
        check("b_w", bus.out_waddr, 0);
        push(32'h30C, 32'h50000001); // b, offs26 high half = 1
        check("b_hi_imm", bus.out_imm, 32'h00040000);
        step();
        bus.ID_allow_in = 1'b0;
        check("dec_drain", bus.occupancy, 0);

        // Reset while full and stalled
        for (int i = 0; i < 4; i++) push(32'h380 + 32'(4 * i), 32'h00101CA4);
        check("pre_rst_occ", bus.occupancy, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", bus.IPD_to_ID_valid, 0);
        check("mid_rst_allow", bus.IPD_allow_in, 1);
        check("mid_rst_occ", bus.occupancy, 0);

        // Wrap-around: steady push/pop pairs, head PC must advance in order
        bus.ID_allow_in = 1'b1;
        push(32'h400, 32'h00101CA4);
        for (int i = 0; i < 10; i++) begin
            check("wrap_occ", bus.occupancy, 1);
            check("wrap_pc", bus.out_pc, 32'h400 + 32'(4 * i));
            push(32'h400 + 32'(4 * (i + 1)), 32'h00101CA4);
        end
        check("wrap_last", bus.out_pc, 32'h428);
        step();
        check("wrap_empty", bus.occupancy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ipd_queue.md
Name: ipd_queue

Overview:
- Parametrised pre-decode stage with an internal instruction queue, placed between IF and ID.
- Each accepted fetch is decoded once on entry: register numbers, immediate, legality flag. The result is stored with its PC and instruction word in a DEPTH-entry FIFO.
- ID reads the decoded head entry.
- Unlike a single-register pre-decode stage, this block absorbs ID stalls without back-pressuring IF every cycle. It also supports flush on branch mispredict, bl link-register write and correct offs26 reassembly.

Parameters:
- DEPTH, 4, queue entries; power of two, >=2.
- PC_WD, 32, width of PC field.
- LINK_REG, 1, register number written by bl.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- IF_to_IPD_valid  in  1  fetch entry present this cycle
- IF_pc  in  PC_WD  PC of fetched instruction
- IF_inst  in  32  instruction word, already registered by IF
- IPD_allow_in  out  1  queue can accept this cycle
- br_taken_cancel  in  1  mispredict flush from ID
- ID_allow_in  in  1  ID consumes head this cycle if valid
- IPD_to_ID_valid  out  1  head entry valid
- out_pc  out  PC_WD  head PC
- out_inst  out  32  head instruction word
- out_raddr1  out  5  read port 1 register
- out_raddr2  out  5  read port 2 register
- out_waddr  out  5  write register, 0 = no write
- out_imm  out  32  extended immediate
- out_illegal  out  1  opcode not in supported subset
- occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Reset values: rd_ptr=wr_ptr=0, count=0, IPD_to_ID_valid=0, IPD_allow_in=1, occupancy=0. Data outputs are don't-care while valid=0, but driven from storage, never X after the first push.
- push = IF_to_IPD_valid & IPD_allow_in & ~br_taken_cancel.
- pop = IPD_to_ID_valid & ID_allow_in & ~br_taken_cancel.
- IPD_allow_in = (count<DEPTH) | ID_allow_in. When full, a push is accepted only together with a pop.
- Latency: a pushed entry is visible at the outputs no earlier than the next cycle. There is no combinational IF-to-ID bypass.
- Simultaneous push and pop: count unchanged, both pointers advance. Push and pop at count==1 is legal. Push and pop at count==DEPTH is legal.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Flush: br_taken_cancel=1 sets count=0 and rd_ptr=wr_ptr at the next edge. A same-cycle push is dropped. The same-cycle pop is suppressed: ID must discard it.
- IPD_to_ID_valid = (count!=0); it is registered-state-derived only.
- Reset asserted mid-operation behaves identically to flush plus pointer zeroing; reset has priority over flush.
- Decode, combinational on IF_inst before write:
  - R-type (add.w sub.w mul.w or nor and xor slt sltu): raddr1=rk[14:10], raddr2=rj[9:5], waddr=rd[4:0].
  - addi.w ori andi srli.w slli.w srai.w jirl ld.w ld.b: raddr1=rj, raddr2=0, waddr=rd.
  - beq bne st.w st.b: raddr1=rj, raddr2=rd, waddr=0.
  - lu12i.w pcaddu12i: waddr=rd, reads 0.
  - bl: waddr=LINK_REG, reads 0.
  - b: all zero.
  - Any other opcode: all fields 0, imm=0, illegal=1.
- Immediates:
  - si12 sign-extended: addi, ld/st.
  - ui12 zero-extended: ori, andi.
  - ui5 zero-extended: shifts.
  - {si20,12'b0}: lu12i, pcaddu12i.
  - SignExtend({inst[25:10],2'b0}): jirl, beq, bne.
  - SignExtend({inst[9:0],inst[25:10],2'b0}): b, bl.
- Opcode compare widths: 17-bit (R-type, shifts), 10-bit (imm ALU, ld/st), 7-bit (lu12i, pcaddu12i), 6-bit (branches).

Test Plan:
- Reset, then push IF_inst=0x00101CA4 (add.w r4,r5,r7), PC=0x1C000000, with ID_allow_in=1 -> next cycle valid=1, raddr1=7, raddr2=5, waddr=4, illegal=0; following cycle valid=0.
- Push 0x02BFFC01 (addi.w r1,r0,-1) -> imm=0xFFFFFFFF, raddr1=0, waddr=1. Push 0x54001000 (bl +16) -> imm=0x00000010, waddr=LINK_REG=1.
- Hold ID_allow_in=0 and push 5 entries at DEPTH=4 -> IPD_allow_in=0 after the 4th, occupancy=4, 5th held by IF. Then raise ID_allow_in -> push and pop in the same cycle, occupancy stays 4, entries leave in FIFO order.
- With 3 entries queued, pulse br_taken_cancel together with IF_to_IPD_valid -> next cycle occupancy=0, valid=0, pushed entry absent. Next push appears alone.
- Push 0xFFFFFFFF -> illegal=1, all reg fields 0, imm=0.
- Assert reset with the queue full while ID stalls -> next cycle valid=0, allow_in=1, occupancy=0. Wrap-around: 10 push/pop pairs, PCs in order.
